// File: rtl/axi_sram_satellite_if.sv
// AXI4 channel bundle between the interconnect mux and its satellites.
// 4-bit IDs, 32-bit address/data, 4-bit write strobes.
interface axi_bus_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport satellite_to_mux (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_satellite.sv
// AXI4 satellite backed by a word-addressed SRAM; independent write and read
// FSMs, one outstanding transaction each, INCR/FIXED/WRAP bursts with SLVERR.
module axi_sram_satellite #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input logic                 CLK,
    input logic                 nRST,
    axi_bus_if.satellite_to_mux bus
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [7:0] len);
        logic ok;
        ok = 1'b0;
        if (size == 3'b010) begin
            case (burst)
                2'b00, 2'b01: ok = 1'b1;
                2'b10:        ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
                default:      ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // WRAP mask is bound-1 = len*4+3, valid for the legal lengths only.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [31:0] mask;
        logic [31:0] n;
        mask = {22'd0, len, 2'b11};
        case (burst)
            2'b01:   n = a + 32'd4;
            2'b10:   n = (a & ~mask) | ((a + 32'd4) & mask);
            default: n = a;
        endcase
        return n;
    endfunction

    logic rst_done;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) rst_done <= 1'b0;
        else       rst_done <= 1'b1;
    end

    // ---------------- write path ----------------
    wstate_t     wstate, wstate_nx;
    logic [3:0]  w_id;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [7:0]  w_cnt;
    logic [1:0]  w_burst;
    logic        w_ok;
    logic        w_err;
    logic        aw_rdy, w_rdy, b_vld;
    logic        aw_hs, w_hs, w_last_beat;

    assign w_last_beat = (w_cnt == w_len);

    always_comb begin
        wstate_nx = wstate;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        b_vld     = 1'b0;
        case (wstate)
            W_IDLE: begin
                aw_rdy = rst_done;
                if (bus.awvalid && rst_done) wstate_nx = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (bus.wvalid && w_last_beat) wstate_nx = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (bus.bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    assign aw_hs = aw_rdy && bus.awvalid;
    assign w_hs  = w_rdy && bus.wvalid;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wstate  <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_ok    <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            wstate <= wstate_nx;
            if (aw_hs) begin
                w_id    <= bus.awid;
                w_addr  <= bus.awaddr;
                w_len   <= bus.awlen;
                w_burst <= bus.awburst;
                w_ok    <= burst_ok(bus.awburst, bus.awsize, bus.awlen);
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_hs) begin
                w_cnt  <= w_cnt + 8'd1;
                w_addr <= next_addr(w_addr, w_burst, w_len);
                if (!w_ok || !in_range(w_addr) || (bus.wlast != w_last_beat)) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_hs && w_ok && in_range(w_addr)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.bvalid  = b_vld;
    assign bus.bid     = w_id;
    assign bus.bresp   = (b_vld && w_err) ? 2'b10 : 2'b00;

    // ---------------- read path ----------------
    rstate_t     rstate, rstate_nx;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [1:0]  r_burst;
    logic        r_ok;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        ar_rdy, r_vld, r_last;
    logic        rd_load;
    logic [31:0] rd_addr;
    logic        rd_ok;

    assign r_last = (rstate == R_DATA) && (r_cnt == r_len);

    always_comb begin
        rstate_nx = rstate;
        ar_rdy    = 1'b0;
        r_vld     = 1'b0;
        rd_load   = 1'b0;
        rd_addr   = r_addr;
        rd_ok     = r_ok;
        case (rstate)
            R_IDLE: begin
                ar_rdy = rst_done;
                if (bus.arvalid && rst_done) begin
                    rstate_nx = R_DATA;
                    rd_load   = 1'b1;
                    rd_addr   = bus.araddr;
                    rd_ok     = burst_ok(bus.arburst, bus.arsize, bus.arlen);
                end
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (bus.rready) begin
                    if (r_last) begin
                        rstate_nx = R_IDLE;
                    end else begin
                        rd_load = 1'b1;
                        rd_addr = next_addr(r_addr, r_burst, r_len);
                    end
                end
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    // The SRAM read happens in the same edge a write may land, so a read of
    // the word being written returns the old contents.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rstate  <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_ok    <= 1'b0;
            r_data  <= '0;
            r_resp  <= '0;
        end else begin
            rstate <= rstate_nx;
            if (ar_rdy && bus.arvalid) begin
                r_id    <= bus.arid;
                r_len   <= bus.arlen;
                r_burst <= bus.arburst;
                r_ok    <= rd_ok;
                r_cnt   <= '0;
            end else if (rd_load) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (rd_load) begin
                r_addr <= rd_addr;
                r_data <= (rd_ok && in_range(rd_addr)) ? mem[word_idx(rd_addr)] : '0;
                r_resp <= (rd_ok && in_range(rd_addr)) ? 2'b00 : 2'b10;
            end
        end
    end

    assign bus.arready = ar_rdy;
    assign bus.rvalid  = r_vld;
    assign bus.rlast   = r_last;
    assign bus.rid     = r_id;
    assign bus.rdata   = r_data;
    assign bus.rresp   = r_resp;

    logic unused;
    assign unused = ^{bus.awlock, bus.awcache, bus.awprot, bus.awqos,
                      bus.arlock, bus.arcache, bus.arprot, bus.arqos};
endmodule

// File: tb/tb_axi_sram_satellite.sv
// Directed scoreboard bench for axi_sram_satellite: expected B/R responses are
// queued when a transaction is driven and checked as the DUT presents them.
module tb_axi_sram_satellite;
    localparam logic [31:0] B = 32'h0001_0000;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic [31:0] data;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] wq[$];
    rexp_t       rq[$];
    bexp_t       bq[$];

    axi_bus_if bus ();

    axi_sram_satellite #(.BASE_ADDR(B), .DEPTH(64)) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input logic badlast, input logic [1:0] resp);
        int    n;
        bexp_t e;
        bq.push_back({id, resp});
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("aw_ready", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        chk("w_latency", bus.wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = wq.pop_front();
            bus.wstrb  = strb;
            bus.wlast  = (i == int'(len)) ^ badlast;
            bus.wvalid = 1'b1;
            n = 0;
            while (bus.wready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            chk("w_ready", bus.wready, 1);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("b_latency", bus.bvalid, 1);
        bus.bready = 1'b1;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        e = bq.pop_front();
        chk("b_resp", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, e});
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic toggle);
        int    n, got, cyc;
        rexp_t e;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'b010;
        bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("ar_ready", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        chk("r_latency", bus.rvalid, 1);
        got = 0;
        cyc = 0;
        while (got <= int'(len) && cyc < 100) begin
            bus.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            e = (rq.size() > 0) ? rq[0] : '0;
            chk("r_beat", {bus.rvalid, bus.rid, bus.rresp, bus.rlast, bus.rdata}, {1'b1, e});
            if (bus.rready) begin
                if (rq.size() > 0) void'(rq.pop_front());
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        chk("r_done", {bus.rvalid, 32'(got)}, {1'b0, 32'(len) + 32'd1});
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                              bus.rlast, bus.bresp, bus.rresp, bus.bid, bus.rid, bus.rdata}, 0);
        nrst = 1'b1;
        #1 chk("ready_gate_first", {bus.awready, bus.arready}, 0);
        @(negedge clk);
        chk("ready_gate_second", {bus.awready, bus.arready}, 2'b11);

        // single write then single read
        wq.push_back(32'hDEADBEEF);
        do_write(4'd3, B + 32'h10, 8'd0, 3'b010, 2'b01, 4'hF, 1'b0, 2'b00);
        rq.push_back({4'd5, 2'b00, 1'b1, 32'hDEADBEEF});
        do_read(4'd5, B + 32'h10, 8'd0, 2'b01, 1'b0);

        // INCR burst, read back with rready toggling
        for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
        do_write(4'd1, B + 32'h20, 8'd3, 3'b010, 2'b01, 4'hF, 1'b0, 2'b00);
        for (int i = 1; i <= 4; i++) rq.push_back({4'd2, 2'b00, (i == 4), 32'(i)});
        do_read(4'd2, B + 32'h20, 8'd3, 2'b01, 1'b1);

        // byte strobes
        wq.push_back(32'hFFFFFFFF);
        do_write(4'd4, B + 32'h40, 8'd0, 3'b010, 2'b01, 4'hF, 1'b0, 2'b00);
        wq.push_back(32'h11223344);
        do_write(4'd4, B + 32'h40, 8'd0, 3'b010, 2'b01, 4'b0101, 1'b0, 2'b00);
        rq.push_back({4'd4, 2'b00, 1'b1, 32'hFF22FF44});
        do_read(4'd4, B + 32'h40, 8'd0, 2'b01, 1'b0);

        // WRAP legal and illegal
        wq.push_back(32'hA); wq.push_back(32'hB); wq.push_back(32'hC); wq.push_back(32'hD);
        do_write(4'd6, B + 32'h30, 8'd3, 3'b010, 2'b01, 4'hF, 1'b0, 2'b00);
        rq.push_back({4'd7, 2'b00, 1'b0, 32'hC});
        rq.push_back({4'd7, 2'b00, 1'b0, 32'hD});
        rq.push_back({4'd7, 2'b00, 1'b0, 32'hA});
        rq.push_back({4'd7, 2'b00, 1'b1, 32'hB});
        do_read(4'd7, B + 32'h38, 8'd3, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) rq.push_back({4'd8, 2'b10, (i == 2), 32'h0});
        do_read(4'd8, B + 32'h30, 8'd2, 2'b10, 1'b0);

        // FIXED burst: both beats hit the same word
        wq.push_back(32'h7); wq.push_back(32'h8);
        do_write(4'd9, B + 32'h58, 8'd1, 3'b010, 2'b00, 4'hF, 1'b0, 2'b00);
        rq.push_back({4'd9, 2'b00, 1'b1, 32'h8});
        do_read(4'd9, B + 32'h58, 8'd0, 2'b01, 1'b0);

        // out of range write must not alias onto word 0
        wq.push_back(32'h5A5A5A5A);
        do_write(4'd1, B, 8'd0, 3'b010, 2'b01, 4'hF, 1'b0, 2'b00);
        wq.push_back(32'h12345678);
        do_write(4'd2, B + 32'h100, 8'd0, 3'b010, 2'b01, 4'hF, 1'b0, 2'b10);
        rq.push_back({4'd3, 2'b00, 1'b1, 32'h5A5A5A5A});
        do_read(4'd3, B, 8'd0, 2'b01, 1'b0);
        rq.push_back({4'd4, 2'b10, 1'b0, 32'h0});
        rq.push_back({4'd4, 2'b10, 1'b1, 32'h0});
        do_read(4'd4, B + 32'h100, 8'd1, 2'b01, 1'b0);
        rq.push_back({4'd5, 2'b10, 1'b1, 32'h0});
        do_read(4'd5, B - 32'h4, 8'd0, 2'b01, 1'b0);

        // bad size is dropped with SLVERR; wlast mismatch flags SLVERR
        wq.push_back(32'h0BADF00D);
        do_write(4'd6, B + 32'h50, 8'd0, 3'b010, 2'b01, 4'hF, 1'b0, 2'b00);
        wq.push_back(32'hCAFE0000);
        do_write(4'd7, B + 32'h50, 8'd0, 3'b001, 2'b01, 4'hF, 1'b0, 2'b10);
        rq.push_back({4'd8, 2'b00, 1'b1, 32'h0BADF00D});
        do_read(4'd8, B + 32'h50, 8'd0, 2'b01, 1'b0);
        wq.push_back(32'h55);
        do_write(4'd9, B + 32'h54, 8'd0, 3'b010, 2'b01, 4'hF, 1'b1, 2'b10);

        // reset in the middle of a write burst and a read burst
        bus.awid = 4'd6; bus.awaddr = B + 32'h60; bus.awlen = 8'd3; bus.awsize = 3'b010;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        for (int n = 0; n < 20 && bus.awready !== 1'b1; n++) @(negedge clk);
        chk("mid_aw_ready", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wdata = 32'h66; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        bus.arid = 4'hA; bus.araddr = B + 32'h20; bus.arlen = 8'd3; bus.arsize = 3'b010;
        bus.arburst = 2'b01; bus.arvalid = 1'b1;
        for (int n = 0; n < 20 && bus.arready !== 1'b1; n++) @(negedge clk);
        chk("mid_ar_ready", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        chk("mid_beat1", {bus.rvalid, bus.rdata}, {1'b1, 32'h1});
        @(negedge clk);
        chk("mid_beat2", {bus.rvalid, bus.wready, bus.rdata}, {2'b11, 32'h2});
        nrst = 1'b0;
        #1 chk("mid_reset_drop", {bus.rvalid, bus.wready, bus.bvalid, bus.awready, bus.arready}, 0);
        bus.rready = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        #1 chk("mid_release_first", {bus.awready, bus.arready}, 0);
        @(negedge clk);
        chk("mid_release_second", {bus.awready, bus.arready}, 2'b11);
        rq.push_back({4'd1, 2'b00, 1'b1, 32'hDEADBEEF});
        do_read(4'd1, B + 32'h10, 8'd0, 2'b01, 1'b0);
        rq.push_back({4'd2, 2'b00, 1'b1, 32'h66});
        do_read(4'd2, B + 32'h60, 8'd0, 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_sram_satellite.md
Name: axi_sram_satellite

Overview:
- AXI4 satellite (responder) backed by a word-addressed on-chip SRAM.
- Sits on the satellite side of the AXI mux through the axi_bus_if satellite_to_mux modport; answers controller bursts routed to it.
- Write path and read path are independent FSMs; one outstanding transaction per direction; full INCR/FIXED/WRAP burst support with byte strobes and SLVERR signalling.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the memory window (DEPTH*4 aligned).
- DEPTH, 1024, memory size in 32-bit words; power of 2, min 16.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- nRST  input  1  asynchronous active-low reset.
- bus  interface  axi_bus_if.satellite_to_mux  AXI4 channels AW/W/B/AR/R (4-bit IDs, 32-bit addr/data, 4-bit strobes).

Behaviour:
- Reset: one clock CLK; nRST asynchronous, active-low. While nRST=0: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid = 0; rdata = 0; both FSMs IDLE. Memory contents are not reset.
- Ready gating: flop rst_done clears on reset and sets on the first CLK edge after nRST rises. awready/arready are asserted only when rst_done=1.
- Ignored inputs: awlock/cache/prot/qos and the ar equivalents are accepted and ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid&awready, capture awid, awaddr, awlen, awsize, awburst; clear err; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready beat writes wdata byte lanes enabled by wstrb to mem[idx]; address then advances.
  - Beat counter runs 0..awlen. On the beat where count==awlen, go to W_RESP. The count governs termination, not wlast; a wlast/count mismatch sets err.
  - W_RESP: bvalid=1, bid=captured awid, bresp=err?2'b10:2'b00. Hold until bready, then return to W_IDLE.
  - Minimum write latency: AW handshake to first wready = 1 cycle; last W beat to bvalid = 1 cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On handshake, capture the AR fields and load rdata from mem[idx of araddr]; rvalid=1 the next cycle (1-cycle latency).
  - R_DATA: rid=captured arid. rlast=1 when beat count==arlen. rresp is per beat: 2'b10 if the burst is illegal or the beat address is out of range, else 2'b00.
  - On rvalid&rready: if rlast, go to R_IDLE with rvalid=0; else advance the address and load the next beat into rdata, rvalid staying 1 (back-to-back beats).
  - While rready=0, rdata/rresp/rlast/rid are held stable.
- Address rules:
  - idx = (addr-BASE_ADDR)>>2.
  - Out of range (addr<BASE_ADDR or addr-BASE_ADDR>=DEPTH*4): the write beat is dropped and err is set; the read beat returns rdata=0 with SLVERR.
  - Low two address bits are ignored for indexing.
- Burst rules (beat size 4 bytes):
  - FIXED (00): address constant.
  - INCR (01): +4 per beat, wrapping at 32 bits without error.
  - WRAP (10): len must be 1/3/7/15, otherwise SLVERR. Wrap boundary is (len+1)*4; next = (addr & ~(bound-1)) | ((addr+4) & (bound-1)).
  - Burst 11, or size != 3'b010: whole burst is SLVERR, writes dropped, reads return 0. Beat count is still honoured and the handshake completes normally.
- Simultaneous read and write to the same word in one cycle: the read beat captures the pre-write contents; the write lands at the end of the cycle.
- Reset mid-burst: all channels drop immediately (async); a partially written burst leaves earlier beats committed; no B/R response is issued for the aborted transaction.

Test Plan:
- Single write 32'hDEADBEEF @BASE+0x10, awid=3, wstrb=4'hF -> bvalid with bid=3, bresp=00; read len0 @0x10, arid=5 -> rdata=DEADBEEF, rid=5, rresp=00, rlast=1, rvalid 1 cycle after AR handshake.
- INCR write len=3 @0x20 with data 1,2,3,4, then INCR read len=3 @0x20 with rready toggled 1,0,1,0,... -> beats 1,2,3,4; rdata held while rready=0; rlast only on beat 4.
- Write 32'hFFFFFFFF @0x40, then write 32'h11223344 with wstrb=4'b0101 -> read returns 32'hFF22FF44.
- WRAP read len=3 @0x38 over words 0x30..0x3C preloaded with A,B,C,D -> beat order C,D,A,B (addresses 0x38,0x3C,0x30,0x34); WRAP len=2 -> all beats rresp=10, rdata=0.
- Write @BASE+DEPTH*4 -> bresp=10, no memory word changes; INCR read len=1 there -> both beats rdata=0, rresp=10; awsize=3'b001 write -> bresp=10.
- nRST pulled low during beat 2 of a 4-beat read with a write burst in W_DATA -> rvalid/wready/bvalid=0 immediately; awready/arready=0 on the first edge after release and 1 from the second edge on; a new single read completes normally.
